// File: rtl/time_set_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : time_set_ctrl
// Brief    : Three-button time/alarm entry controller driving the timekeeper
//            set interface (BCD digits plus held LD_time/LD_alarm strobe).
//            Optional build macro AUTO_REPEAT_EN adds btn_inc auto-repeat.
// Revision : 1.0 - initial release
// ============================================================================
module time_set_ctrl #(
    parameter int DEB_CYCLES = 2,
    parameter int LD_HOLD    = 12,
    parameter int TIMEOUT    = 300,
    parameter int REPEAT_DLY = 8,
    parameter int REPEAT_PER = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_inc,
    input  logic       sel_alarm,
    output logic [1:0] H_in1,
    output logic [3:0] H_in0,
    output logic [3:0] M_in1,
    output logic [3:0] M_in0,
    output logic       LD_time,
    output logic       LD_alarm,
    output logic       editing,
    output logic [1:0] edit_digit,
    output logic       target
);

    localparam int c_TO_W   = $clog2(TIMEOUT + 1);
    localparam int c_HOLD_W = $clog2(LD_HOLD + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EDIT_H1 = 3'd1,
        S_EDIT_H0 = 3'd2,
        S_EDIT_M1 = 3'd3,
        S_EDIT_M0 = 3'd4,
        S_COMMIT  = 3'd5
    } state_t;

    // Bit order: 0 = mode, 1 = next, 2 = inc
    logic [2:0] w_raw;
    logic [2:0] w_press;
    assign w_raw = {btn_inc, btn_next, btn_mode};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_btn
            logic       r_s1;
            logic       r_s2;
            logic       r_lvl;
            logic       r_lvl_q;
            logic [3:0] r_cnt;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_s1    <= 1'b0;
                    r_s2    <= 1'b0;
                    r_lvl   <= 1'b0;
                    r_lvl_q <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_s1    <= w_raw[gi];
                    r_s2    <= r_s1;
                    r_lvl_q <= r_lvl;
                    if (r_s2 == r_lvl) begin
                        r_cnt <= '0;
                    end else if (r_cnt == 4'(DEB_CYCLES - 1)) begin
                        r_lvl <= r_s2;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
            end

            assign w_press[gi] = r_lvl & ~r_lvl_q;
        end
    endgenerate

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_h1, w_h1_nxt;
    logic [3:0]            r_h0, w_h0_nxt;
    logic [3:0]            r_m1, w_m1_nxt;
    logic [3:0]            r_m0, w_m0_nxt;
    logic                  r_target, w_target_nxt;
    logic                  r_ld_time, w_ld_time_nxt;
    logic                  r_ld_alarm, w_ld_alarm_nxt;
    logic                  r_editing, w_editing_nxt;
    logic [1:0]            r_digit, w_digit_nxt;
    logic [c_TO_W-1:0]     r_to_cnt, w_to_nxt;
    logic [c_HOLD_W-1:0]   r_hold_cnt, w_hold_nxt;

    logic w_in_edit;
    logic w_repeat;
    logic w_ev_mode;
    logic w_ev_next;
    logic w_ev_inc;

    assign w_in_edit = (r_state == S_EDIT_H1) || (r_state == S_EDIT_H0) ||
                       (r_state == S_EDIT_M1) || (r_state == S_EDIT_M0);

    // mode beats next beats inc; losers in the same cycle are discarded
    assign w_ev_mode = w_press[0];
    assign w_ev_next = w_press[1] & ~w_press[0];
    assign w_ev_inc  = (w_press[2] | w_repeat) & ~w_press[0] & ~w_press[1];

`ifdef AUTO_REPEAT_EN
    localparam int c_REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int c_REP_W   = $clog2(c_REP_MAX + 1);

    logic               w_inc_held;
    logic [c_REP_W-1:0] r_rep_cnt;
    logic               r_rep_first;

    assign w_inc_held = g_btn[2].r_lvl;
    assign w_repeat   = w_in_edit & w_inc_held & ~w_press[2] &
                        (r_rep_cnt == (r_rep_first ? c_REP_W'(REPEAT_DLY) : c_REP_W'(REPEAT_PER)));

    // r_rep_cnt counts cycles since the press or the previous repeat
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b1;
        end else if (!(w_in_edit && w_inc_held)) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b1;
        end else if (w_press[2] || w_repeat) begin
            r_rep_cnt   <= c_REP_W'(1);
            r_rep_first <= w_press[2];
        end else begin
            r_rep_cnt   <= r_rep_cnt + c_REP_W'(1);
        end
    end
`else
    assign w_repeat = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_h1       <= '0;
            r_h0       <= '0;
            r_m1       <= '0;
            r_m0       <= '0;
            r_target   <= 1'b0;
            r_ld_time  <= 1'b0;
            r_ld_alarm <= 1'b0;
            r_editing  <= 1'b0;
            r_digit    <= '0;
            r_to_cnt   <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_h1       <= w_h1_nxt;
            r_h0       <= w_h0_nxt;
            r_m1       <= w_m1_nxt;
            r_m0       <= w_m0_nxt;
            r_target   <= w_target_nxt;
            r_ld_time  <= w_ld_time_nxt;
            r_ld_alarm <= w_ld_alarm_nxt;
            r_editing  <= w_editing_nxt;
            r_digit    <= w_digit_nxt;
            r_to_cnt   <= w_to_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_h1_nxt     = r_h1;
        w_h0_nxt     = r_h0;
        w_m1_nxt     = r_m1;
        w_m0_nxt     = r_m0;
        w_target_nxt = r_target;
        w_hold_nxt   = r_hold_cnt;
        w_to_nxt     = '0;

        case (r_state)
            S_IDLE: begin
                if (w_ev_mode) begin
                    w_state_nxt  = S_EDIT_H1;
                    w_target_nxt = sel_alarm;
                end
            end
            S_EDIT_H1, S_EDIT_H0, S_EDIT_M1, S_EDIT_M0: begin
                if (w_ev_mode) begin
                    w_state_nxt = S_IDLE;
                end else if (w_ev_next) begin
                    case (r_state)
                        S_EDIT_H1: w_state_nxt = S_EDIT_H0;
                        S_EDIT_H0: w_state_nxt = S_EDIT_M1;
                        S_EDIT_M1: w_state_nxt = S_EDIT_M0;
                        default: begin
                            w_state_nxt = S_COMMIT;
                            w_hold_nxt  = '0;
                        end
                    endcase
                end else if (w_ev_inc) begin
                    case (r_state)
                        S_EDIT_H1: begin
                            w_h1_nxt = (r_h1 >= 2'd2) ? 2'd0 : r_h1 + 2'd1;
                            // entering the 20s would make 24..29 reachable
                            if (r_h1 == 2'd1 && r_h0 > 4'd3) begin
                                w_h0_nxt = 4'd3;
                            end
                        end
                        S_EDIT_H0: w_h0_nxt = (r_h0 >= ((r_h1 == 2'd2) ? 4'd3 : 4'd9)) ? 4'd0 : r_h0 + 4'd1;
                        S_EDIT_M1: w_m1_nxt = (r_m1 >= 4'd5) ? 4'd0 : r_m1 + 4'd1;
                        default:   w_m0_nxt = (r_m0 >= 4'd9) ? 4'd0 : r_m0 + 4'd1;
                    endcase
                end else if (r_to_cnt == c_TO_W'(TIMEOUT - 1)) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_to_nxt = r_to_cnt + c_TO_W'(1);
                end
            end
            S_COMMIT: begin
                if (r_hold_cnt == c_HOLD_W'(LD_HOLD - 1)) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_hold_nxt = r_hold_cnt + c_HOLD_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_editing_nxt = 1'b0;
        w_digit_nxt   = 2'd0;
        case (w_state_nxt)
            S_EDIT_H1: w_editing_nxt = 1'b1;
            S_EDIT_H0: begin w_editing_nxt = 1'b1; w_digit_nxt = 2'd1; end
            S_EDIT_M1: begin w_editing_nxt = 1'b1; w_digit_nxt = 2'd2; end
            S_EDIT_M0: begin w_editing_nxt = 1'b1; w_digit_nxt = 2'd3; end
            default: ;
        endcase

        w_ld_time_nxt  = (w_state_nxt == S_COMMIT) & ~w_target_nxt;
        w_ld_alarm_nxt = (w_state_nxt == S_COMMIT) &  w_target_nxt;
    end

    assign H_in1      = r_h1;
    assign H_in0      = r_h0;
    assign M_in1      = r_m1;
    assign M_in0      = r_m0;
    assign LD_time    = r_ld_time;
    assign LD_alarm   = r_ld_alarm;
    assign editing    = r_editing;
    assign edit_digit = r_digit;
    assign target     = r_target;

endmodule
`default_nettype wire

// File: tb/tb_time_set_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_time_set_ctrl
// Brief    : Directed scoreboard bench for time_set_ctrl (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_time_set_ctrl;

    localparam int c_LD_HOLD = 12;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_mode;
    logic       btn_next;
    logic       btn_inc;
    logic       sel_alarm;
    logic [1:0] H_in1;
    logic [3:0] H_in0;
    logic [3:0] M_in1;
    logic [3:0] M_in0;
    logic       LD_time;
    logic       LD_alarm;
    logic       editing;
    logic [1:0] edit_digit;
    logic       target;

    typedef struct packed {
        logic       alarm;
        logic [1:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    time_set_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .btn_mode   (btn_mode),
        .btn_next   (btn_next),
        .btn_inc    (btn_inc),
        .sel_alarm  (sel_alarm),
        .H_in1      (H_in1),
        .H_in0      (H_in0),
        .M_in1      (M_in1),
        .M_in0      (M_in0),
        .LD_time    (LD_time),
        .LD_alarm   (LD_alarm),
        .editing    (editing),
        .edit_digit (edit_digit),
        .target     (target)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic m, input logic nx, input logic i);
        btn_mode = m;
        btn_next = nx;
        btn_inc  = i;
        tick(6);
        btn_mode = 1'b0;
        btn_next = 1'b0;
        btn_inc  = 1'b0;
        tick(6);
    endtask

    // Press next from EDIT_M0 and score the resulting load pulse
    task automatic commit_and_check(input string tag);
        int   hi    = 0;
        bit   seen  = 1'b0;
        bit   other = 1'b0;
        exp_t e     = '0;
        btn_next = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (c == 6) btn_next = 1'b0;
            if (LD_time || LD_alarm) begin
                if (!seen) begin
                    seen = 1'b1;
                    e = sb.pop_front();
                    check({tag, "_strobe"}, {LD_alarm, LD_time}, e.alarm ? 2'b10 : 2'b01);
                    check({tag, "_digits"}, {H_in1, H_in0, M_in1, M_in0}, {e.h1, e.h0, e.m1, e.m0});
                end
                hi++;
                if (e.alarm ? LD_time : LD_alarm) other = 1'b1;
            end
        end
        check({tag, "_seen"}, seen, 1);
        check({tag, "_len"}, hi, c_LD_HOLD);
        check({tag, "_other"}, other, 0);
        check({tag, "_frozen"}, {H_in1, H_in0, M_in1, M_in0}, {e.h1, e.h0, e.m1, e.m0});
        check({tag, "_idle"}, editing, 0);
    endtask

    initial begin
        bit found;
        bit ld_seen;
        reset     = 1'b1;
        btn_mode  = 1'b0;
        btn_next  = 1'b0;
        btn_inc   = 1'b0;
        sel_alarm = 1'b0;
        tick(3);
        check("rst_digits", {H_in1, H_in0, M_in1, M_in0}, 0);
        check("rst_ld", {LD_time, LD_alarm}, 0);
        check("rst_edit", {editing, edit_digit, target}, 0);
        reset = 1'b0;
        tick(2);

        // Session 1: time set to 04:37
        press(1, 0, 0);
        check("s1_enter", {editing, edit_digit, target}, 4'b1000);
        press(0, 1, 0);
        check("s1_dig_h0", edit_digit, 1);
        repeat (4) press(0, 0, 1);
        check("s1_h0", H_in0, 4);
        press(0, 1, 0);
        repeat (3) press(0, 0, 1);
        check("s1_m1", M_in1, 3);
        press(0, 1, 0);
        check("s1_dig_m0", edit_digit, 3);
        repeat (7) press(0, 0, 1);
        check("s1_m0", M_in0, 7);
        sb.push_back(exp_t'{1'b0, 2'd0, 4'd4, 4'd3, 4'd7});
        commit_and_check("s1");

        // Session 2: alarm, H1 to 2 clamps H0 4 -> 3
        sel_alarm = 1'b1;
        press(1, 0, 0);
        check("s2_target", target, 1);
        sel_alarm = 1'b0;
        press(0, 0, 1);
        check("s2_h1_1", {H_in1, H_in0}, {2'd1, 4'd4});
        press(0, 0, 1);
        check("s2_h1_2", {H_in1, H_in0}, {2'd2, 4'd3});
        check("s2_target_latched", target, 1);
        repeat (3) press(0, 1, 0);
        sb.push_back(exp_t'{1'b1, 2'd2, 4'd3, 4'd3, 4'd7});
        commit_and_check("s2");

        // Session 3: H1 wrap, H0 to 9, abort, clamp on 1 -> 2, H0 wrap 3 -> 0
        press(1, 0, 0);
        press(0, 0, 1);
        check("s3_h1_wrap", H_in1, 0);
        press(0, 0, 1);
        press(0, 1, 0);
        repeat (6) press(0, 0, 1);
        check("s3_h19", {H_in1, H_in0}, {2'd1, 4'd9});
        press(1, 0, 0);
        check("s3_abort", {editing, LD_time, LD_alarm}, 0);
        press(1, 0, 0);
        btn_inc = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (H_in1 == 2'd2) begin
                found = 1'b1;
                break;
            end
        end
        check("s3_h1_to2", found, 1);
        check("s3_clamp_same_cycle", H_in0, 3);
        btn_inc = 1'b0;
        tick(6);
        press(0, 1, 0);
        press(0, 0, 1);
        check("s3_h0_wrap", H_in0, 0);

        // Session 4: glitch rejected, simultaneous press -> mode only
        btn_inc = 1'b1;
        tick(1);
        btn_inc = 1'b0;
        tick(10);
        check("s4_glitch", {edit_digit, H_in0}, {2'd1, 4'd0});
        press(1, 1, 1);
        check("s4_prio_state", {editing, edit_digit}, 0);
        check("s4_prio_digits", {H_in1, H_in0, M_in1, M_in0}, {2'd2, 4'd0, 4'd3, 4'd7});
        press(0, 0, 1);
        press(0, 1, 0);
        check("s4_idle_ignore", {editing, H_in1, H_in0, M_in1, M_in0}, {1'b0, 2'd2, 4'd0, 4'd3, 4'd7});

        // Session 5: timeout with no load, digits retained
        press(1, 0, 0);
        ld_seen = 1'b0;
        for (int c = 0; c < 250; c++) begin
            @(negedge clk);
            if (LD_time || LD_alarm) ld_seen = 1'b1;
        end
        check("s5_still_edit", editing, 1);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (LD_time || LD_alarm) ld_seen = 1'b1;
        end
        check("s5_timeout", editing, 0);
        check("s5_no_ld", ld_seen, 0);
        check("s5_digits", {H_in1, H_in0, M_in1, M_in0}, {2'd2, 4'd0, 4'd3, 4'd7});

        // Session 6: reset during commit drops the strobe at once
        press(1, 0, 0);
        repeat (3) press(0, 1, 0);
        btn_next = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (LD_time) begin
                found = 1'b1;
                break;
            end
        end
        check("s6_ld_rise", found, 1);
        tick(3);
        #2 reset = 1'b1;
        #1 check("s6_async_drop", {LD_time, LD_alarm, editing}, 0);
        btn_next = 1'b0;
        tick(2);
        check("s6_rst_digits", {H_in1, H_in0, M_in1, M_in0}, 0);
        reset = 1'b0;
        tick(2);

`ifdef AUTO_REPEAT_EN
        // Hold inc on M0: press + first repeat + 4 periodic repeats
        press(1, 0, 0);
        repeat (3) press(0, 1, 0);
        check("ar_dig_m0", edit_digit, 3);
        btn_inc = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (M_in0 == 4'd1) begin
                found = 1'b1;
                break;
            end
        end
        check("ar_press", found, 1);
        tick(20);
        check("ar_m0", M_in0, 6);
        btn_inc = 1'b0;
        tick(8);
        press(1, 0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
